// File: rtl/pipeline_exe_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_exe_muldiv_if
// Purpose  : EXE-stage handshake between the pipeline and the RV32M
//            multiply/divide unit (request, stall, completion, result).
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_exe_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Pipeline side: issues the M-op and watches stall/completion.
  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  // Unit side.
  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_exe_muldiv
// Purpose  : Multi-cycle RV32M multiply/divide unit in the EXE stage.
//            Radix-2 shift-add multiply, restoring divide, RISC-V special
//            divide cases resolved in one cycle.
// Options  : MULDIV_FAST_MUL_EN - single-cycle 33x33 signed multiply.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_exe_muldiv #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  pipeline_exe_muldiv_if.slave bus
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [4:0] LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // Latched operation context
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd;       // |A| for multiply, |B| for divide
  logic [2*XLEN-1:0] acc;        // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [4:0]        count;
  logic              neg_res;    // negate product / quotient
  logic              neg_rem;    // negate remainder (dividend sign)
  logic [XLEN-1:0]   result;

  // Request decode
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            accept;
  logic            fast_path;

  assign op  = bus.op_i;
  assign rs1 = bus.rs1_i;
  assign rs2 = bus.rs2_i;

  // A new op is taken only from IDLE; flush wins over start, reset over all.
  assign accept = resetn && (state == IDLE) && bus.start_i && !bus.flush_i;

  // Operand signedness, magnitudes and the one-cycle special divide cases.
  always_comb begin
    is_div   = op[2];
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && rs1[XLEN-1];
    b_neg    = b_signed && rs2[XLEN-1];
    a_mag    = a_neg ? ({XLEN{1'b0}} - rs1) : rs1;
    b_mag    = b_neg ? ({XLEN{1'b0}} - rs2) : rs2;
    div_zero = is_div && (rs2 == {XLEN{1'b0}});
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
    special  = div_zero || div_ovf;
    // Divide by zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (div_zero)
      special_res = op[1] ? rs1 : {XLEN{1'b1}};
    else
      special_res = op[1] ? {XLEN{1'b0}} : rs1;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Each operand is a 33-bit signed value (sign bit = a_neg / b_neg);
  // extending to 64 bits makes the low 64 product bits exact.
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  assign fast_a    = {{XLEN{a_neg}}, rs1};
  assign fast_b    = {{XLEN{b_neg}}, rs2};
  assign fast_prod = fast_a * fast_b;
  assign fast_res  = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  assign fast_path = special || !is_div;
`else
  assign fast_path = special;
`endif

  // One radix-2 iteration step and the sign-corrected final result.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;   // 33-bit partial remainder after shift-in
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin;
  logic [XLEN-1:0]   rem_fin;
  logic [XLEN-1:0]   calc_res;

  // Datapath step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // Remainder stays below the divisor, so the difference fits in XLEN bits.
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (op_q[2])
      acc_step = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};

    prod_fin = neg_res ? ({(2*XLEN){1'b0}} - acc_step) : acc_step;
    quo_fin  = neg_res ? ({XLEN{1'b0}} - acc_step[XLEN-1:0]) : acc_step[XLEN-1:0];
    rem_fin  = neg_rem ? ({XLEN{1'b0}} - acc_step[2*XLEN-1:XLEN]) : acc_step[2*XLEN-1:XLEN];

    case (op_q)
      OP_MUL:                        calc_res = prod_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               calc_res = quo_fin;
      OP_REM, OP_REMU:               calc_res = rem_fin;
      default:                       calc_res = rem_fin;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic; flush aborts from any state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = fast_path ? DONE : CALC;
      CALC: if (count == LAST_STEP) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush_i)
      state_nx = IDLE;
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q    <= 3'b000;
      opnd    <= {XLEN{1'b0}};
      acc     <= {(2*XLEN){1'b0}};
      count   <= 5'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      result  <= {XLEN{1'b0}};
    end else if (accept) begin
      op_q    <= op;
      opnd    <= is_div ? b_mag : a_mag;
      acc     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      count   <= 5'd0;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (special)
        result <= special_res;
`ifdef MULDIV_FAST_MUL_EN
      else if (!is_div) begin
        acc    <= fast_prod;
        result <= fast_res;
      end
`endif
    end else if ((state == CALC) && !bus.flush_i) begin
      acc   <= acc_step;
      count <= count + 5'd1;
      if (count == LAST_STEP)
        result <= calc_res;
    end
  end

  assign bus.busy_o   = accept || (state == CALC);
  assign bus.done_o   = (state == DONE);
  assign bus.result_o = result;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_exe_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_exe_muldiv
// Purpose  : Self-checking bench for pipeline_exe_muldiv: directed RV32M
//            vectors, random ops against an arithmetic reference model,
//            flush, mid-op reset and back-to-back issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_exe_muldiv;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  pipeline_exe_muldiv_if #(.XLEN(32)) bus ();

  pipeline_exe_muldiv #(.XLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NDIR = 12;
  localparam logic [2:0]  D_OP  [NDIR] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6,
                                           3'd4, 3'd6, 3'd1, 3'd3, 3'd0, 3'd2};
  localparam logic [31:0] D_A   [NDIR] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                           32'd5, 32'd5, 32'h80000000, 32'h80000000,
                                           32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] D_B   [NDIR] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] D_EXP [NDIR] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                           32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0,
                                           32'h40000000, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF};

  // Reference: RISC-V M-extension semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint    sa, sb, sp;
    logic [63:0] up;
    int        ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = sa * sb; up = sp; return up[63:32]; end
      3'd2: begin sp = sa * longint'({32'd0, b}); up = sp; return up[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Expected cycles from accept to done.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Issue one op, observe completion; reports busy/done-pulse anomalies as counts.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output int busy_err, output int hold_err);
    busy_err = 0;
    hold_err = 0;
    lat = -1;
    res = 32'hx;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    #1;
    if (bus.busy_o !== 1'b1) busy_err++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        lat = c;
        res = bus.result_o;
        if (bus.busy_o !== 1'b0) busy_err++;
        break;
      end else if (bus.busy_o !== 1'b1) begin
        busy_err++;
      end
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    if (bus.done_o !== 1'b0 || bus.result_o !== res) hold_err++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i = 3'd0;
    bus.rs1_i = 32'd0;
    bus.rs2_i = 32'd0;
    repeat (3) @(negedge clk);
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
    total++; if (bus.result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", bus.result_o); end
    resetn = 1'b1;
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", bus.busy_o, bus.done_o);
    end
  endtask

  task automatic test_directed();
    int lat, be, he;
    logic [31:0] res;
    for (int i = 0; i < NDIR; i++) begin
      run_op(D_OP[i], D_A[i], D_B[i], lat, res, be, he);
      total++; if (res !== D_EXP[i]) begin
        bad++; $display("FAIL dir%0d_result op=%0d a=%h b=%h got=%h want=%h", i, D_OP[i], D_A[i], D_B[i], res, D_EXP[i]);
      end
      total++; if (lat !== exp_lat(D_OP[i], D_A[i], D_B[i])) begin
        bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, exp_lat(D_OP[i], D_A[i], D_B[i]));
      end
      total++; if (be !== 0) begin bad++; $display("FAIL dir%0d_busy errors=%0d want=0", i, be); end
      total++; if (he !== 0) begin bad++; $display("FAIL dir%0d_pulse_hold errors=%0d want=0", i, he); end
    end
  endtask

  task automatic test_random();
    int lat, be, he;
    logic [31:0] res, a, b, exp;
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      exp = ref_model(op, a, b);
      run_op(op, a, b, lat, res, be, he);
      total++; if (res !== exp) begin
        bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, exp);
      end
      total++; if (lat !== exp_lat(op, a, b)) begin
        bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, exp_lat(op, a, b));
      end
      total++; if (be !== 0 || he !== 0) begin
        bad++; $display("FAIL rnd%0d_handshake busy_err=%0d hold_err=%0d want 0/0", i, be, he);
      end
    end
  endtask

  task automatic test_flush();
    int lat;
    int early_done;
    early_done = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd5; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done_o !== 1'b0) early_done++;
    end
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || early_done != 0) begin
      bad++; $display("FAIL flush_abort busy=%b done=%b early_done=%0d want 0/0/0", bus.busy_o, bus.done_o, early_done);
    end
    bus.start_i = 1'b1; bus.rs1_i = 32'd100; bus.rs2_i = 32'd7;
    #1;
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL flush_reaccept_busy got=%b want=1", bus.busy_o); end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin lat = c; break; end
    end
    total++; if (lat != 33 || bus.result_o !== 32'd14) begin
      bad++; $display("FAIL flush_restart lat=%0d result=%h want 33/0000000e", lat, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd4; bus.rs1_i = 32'd77; bus.rs2_i = 32'd5;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'h0) begin
      bad++; $display("FAIL reset_mid busy=%b done=%b result=%h want 0/0/00000000", bus.busy_o, bus.done_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    lat = -1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd5; bus.rs1_i = 32'd200; bus.rs2_i = 32'd9;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin lat = c; break; end
    end
    total++; if (lat != 33 || bus.result_o !== 32'd22) begin
      bad++; $display("FAIL b2b_first lat=%0d result=%h want 33/00000016", lat, bus.result_o);
    end
    // Keep start high through DONE with the next op's operands.
    bus.op_i = 3'd7; bus.rs1_i = 32'd200; bus.rs2_i = 32'd9;
    @(negedge clk);
    total++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      bad++; $display("FAIL b2b_gap done=%b busy=%b want 0/1", bus.done_o, bus.busy_o);
    end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin lat = c; break; end
    end
    total++; if (lat != 33 || bus.result_o !== 32'd2) begin
      bad++; $display("FAIL b2b_second lat=%0d result=%h want 33/00000002", lat, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
